// File: rtl/pc_next_unit.sv
// Registered program counter with next-PC target generation and a one-entry
// redirect buffer that holds a redirect raised while the PC is stalled.
module pc_next_unit #(
  parameter int                WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [31:0]       EXC_VECTOR = 32'h0000_0080
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_write,
  input  logic [2:0]        sel,
  input  logic              redir_valid,
  input  logic              branch_cond,
  input  logic              link,
  input  logic [15:0]       imm16,
  input  logic [WIDTH-7:0]  instr_index,
  input  logic [WIDTH-1:0]  reg_target,
  output logic [WIDTH-1:0]  pc_out,
  output logic [WIDTH-1:0]  pc_plus4,
  output logic [WIDTH-1:0]  link_out,
  output logic              pending,
  output logic              addr_err
);

  typedef enum logic [2:0] {
    SEL_SEQ = 3'd0,
    SEL_BR  = 3'd1,
    SEL_J   = 3'd2,
    SEL_JR  = 3'd3,
    SEL_EXC = 3'd4
  } sel_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] EXC_TARGET = WIDTH'(EXC_VECTOR);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] link_q, link_d;
  logic             addr_err_q, addr_err_d;
  logic [WIDTH-1:0] buf_tgt_q, buf_tgt_d;
  logic [WIDTH-1:0] buf_ret_q, buf_ret_d;
  logic             buf_link_q, buf_link_d;
  logic             buf_mis_q, buf_mis_d;

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] br_offset;
  logic [WIDTH-1:0] target;
  logic             redirect;
  logic             misaligned;
  logic             link_req;
  logic             exc_now;

  // Target generation: everything follows pc_q combinationally.
  always_comb begin
    seq_pc     = pc_q + WIDTH'(4);
    br_offset  = WIDTH'($signed(imm16)) << 2;
    redirect   = redir_valid && (sel == SEL_BR || sel == SEL_J ||
                                 sel == SEL_JR || sel == SEL_EXC);
    misaligned = redirect && (sel == SEL_JR) && (reg_target[1:0] != 2'b00);
    link_req   = redirect && link && (sel == SEL_J || sel == SEL_JR);
    exc_now    = redir_valid && (sel == SEL_EXC);
    target     = seq_pc;
    if (redirect) begin
      case (sel)
        SEL_BR:  target = branch_cond ? (seq_pc + br_offset) : seq_pc;
        SEL_J:   target = {pc_q[WIDTH-1:WIDTH-4], instr_index, 2'b00};
        SEL_JR:  target = misaligned ? EXC_TARGET : reg_target;
        SEL_EXC: target = EXC_TARGET;
        default: target = seq_pc;
      endcase
    end
  end

  // Next-state logic for the PC, link register and redirect buffer.
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    link_d     = link_q;
    addr_err_d = 1'b0;
    buf_tgt_d  = buf_tgt_q;
    buf_ret_d  = buf_ret_q;
    buf_link_d = buf_link_q;
    buf_mis_d  = buf_mis_q;

    case (state_q)
      ST_EMPTY: begin
        if (pc_write) begin
          pc_d       = target;
          addr_err_d = misaligned;
          if (link_req) link_d = seq_pc;
        end else if (redirect) begin
          state_d    = ST_HELD;
          buf_tgt_d  = target;
          buf_ret_d  = seq_pc;
          buf_link_d = link_req;
          buf_mis_d  = misaligned;
        end
      end
      ST_HELD: begin
        if (pc_write) begin
          state_d = ST_EMPTY;
          if (exc_now) begin
            pc_d = EXC_TARGET;
          end else begin
            pc_d       = buf_tgt_q;
            addr_err_d = buf_mis_q;
            if (buf_link_q) link_d = buf_ret_q;
          end
        end else if (exc_now) begin
          // An exception displaces whatever redirect is waiting.
          buf_tgt_d  = EXC_TARGET;
          buf_link_d = 1'b0;
          buf_mis_d  = 1'b0;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      pc_q       <= RESET_PC;
      link_q     <= '0;
      addr_err_q <= 1'b0;
      buf_tgt_q  <= '0;
      buf_ret_q  <= '0;
      buf_link_q <= 1'b0;
      buf_mis_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      link_q     <= link_d;
      addr_err_q <= addr_err_d;
      buf_tgt_q  <= buf_tgt_d;
      buf_ret_q  <= buf_ret_d;
      buf_link_q <= buf_link_d;
      buf_mis_q  <= buf_mis_d;
    end
  end

  assign pc_out   = pc_q;
  assign pc_plus4 = seq_pc;
  assign link_out = link_q;
  assign pending  = (state_q == ST_HELD);
  assign addr_err = addr_err_q;

endmodule
